keypad_hold_detector: RTL and testbench

//   Parametrised successor to the fixed 10-key / 7-cycle hold counter in input_control.

---
 rtl/keypad_hold_detector.sv | 176 +++++++++++++++++
 tb/tb_keypad_hold_detector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_hold_detector.sv
// keypad_hold_detector
//   Watches a one-hot keypad bus and counts consecutive sampling edges on which
//   a single key is held. Once HOLD_CYCLES consecutive edges have seen the same
//   key, it emits a one-cycle press pulse on out and publishes the key index on
//   key_code. Two or more keys at once are rejected and flagged on multi.
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     defined   -> after the first pulse, a further pulse every REPEAT_CYCLES
//                  edges while the same key stays held.
//     undefined -> one pulse per press.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no key being tracked
//   COUNT  | one key held, counting towards the hold threshold
//   FIRED  | threshold reached, waiting for release or a different key
//   REPEAT | (auto-repeat only) a repeat pulse was issued, same rules as FIRED
module keypad_hold_detector #(
    parameter int NUM_KEYS      = 10,
    parameter int HOLD_CYCLES   = 7,
    parameter int REPEAT_CYCLES = 4,
    localparam int CODE_W       = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic                out,
    output logic [CODE_W-1:0]   key_code,
    output logic                multi,
    output logic                busy
);

    // The counter only has to reach the larger of the two thresholds minus one,
    // and it is reset whenever a threshold is hit, so it can never wrap.
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        FIRED  = 2'd2
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        REPEAT = 2'd3
`endif
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CODE_W-1:0]  held;

    logic [1:0]         n_set;
    logic [CODE_W-1:0]  idx;
    logic               is_single;
    logic               is_multi;
    logic               is_none;
    logic               same_key;

    // Classify the current keypad sample: number of lines high (saturating at
    // two) and the index of the highest line that is high.
    always_comb begin
        n_set = 2'd0;
        idx   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keypad[i]) begin
                idx = CODE_W'(i);
                if (n_set != 2'd2) begin
                    n_set = n_set + 2'd1;
                end
            end
        end
    end

    assign is_none   = (n_set == 2'd0);
    assign is_single = (n_set == 2'd1);
    assign is_multi  = (n_set == 2'd2);
    assign same_key  = is_single && (idx == held);

    // Hold-detection FSM with all outputs registered; busy mirrors the next state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            cnt      <= '0;
            held     <= '0;
            out      <= 1'b0;
            key_code <= '0;
            multi    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            out   <= 1'b0;
            multi <= is_multi;

            case (state)
                IDLE: begin
                    if (is_single) begin
                        held  <= idx;
                        cnt   <= CNT_ONE;
                        state <= COUNT;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                COUNT: begin
                    if (same_key) begin
                        if (cnt == HOLD_LAST) begin
                            out      <= 1'b1;
                            key_code <= held;
                            cnt      <= '0;
                            state    <= FIRED;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                        busy <= 1'b1;
                    end else if (is_single) begin
                        // A different key restarts the hold from its first edge.
                        held <= idx;
                        cnt  <= CNT_ONE;
                        busy <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

`ifdef KEYPAD_AUTOREPEAT_EN
                FIRED, REPEAT: begin
`else
                FIRED: begin
`endif
                    if (is_none) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (is_single && !same_key) begin
                        // A new key pressed straight over the old one is tracked
                        // immediately so it is never lost.
                        held  <= idx;
                        cnt   <= CNT_ONE;
                        state <= COUNT;
                        busy  <= 1'b1;
                    end else if (same_key) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (cnt == REP_LAST) begin
                            out   <= 1'b1;
                            cnt   <= '0;
                            state <= REPEAT;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
`endif
                        busy <= 1'b1;
                    end else begin
                        // Several lines high: hold position, no pulse.
                        busy <= 1'b1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_hold_detector.sv
// Directed bench for keypad_hold_detector with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the edge just taken.
module tb_keypad_hold_detector;

    logic       clk = 1'b0;
    logic       clear;
    logic [9:0] keypad;
    logic       out;
    logic [3:0] key_code;
    logic       multi;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    logic exp_out;

    keypad_hold_detector dut (
        .clk      (clk),
        .clear    (clear),
        .keypad   (keypad),
        .out      (out),
        .key_code (key_code),
        .multi    (multi),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s edge %0d: observed %0d expected %0d", tag, e, obs, expv);
        end
    endtask

    initial begin
        clear  = 1'b1;
        keypad = '0;
        tick();
        tick();
        chk("rst_out", 0, 32'(out), 0);
        chk("rst_code", 0, 32'(key_code), 0);
        chk("rst_multi", 0, 32'(multi), 0);
        chk("rst_busy", 0, 32'(busy), 0);

        // Key 0 held 10 edges: single pulse after edge 7.
        clear  = 1'b0;
        keypad = 10'b0000000001;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("t1_out", e, 32'(out), 32'(e == 7));
            chk("t1_busy", e, 32'(busy), 1);
            chk("t1_multi", e, 32'(multi), 0);
            if (e >= 7) chk("t1_code", e, 32'(key_code), 0);
        end
        keypad = '0;
        tick();
        chk("t1_rel_busy", 11, 32'(busy), 0);
        chk("t1_rel_out", 11, 32'(out), 0);

        // Key 3 released after 5 edges: no pulse.
        keypad = 10'b0000001000;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("t2_out", e, 32'(out), 0);
            chk("t2_busy", e, 32'(busy), 1);
        end
        keypad = '0;
        tick();
        chk("t2_rel_busy", 6, 32'(busy), 0);
        chk("t2_rel_code", 6, 32'(key_code), 0);
        chk("t2_rel_out", 6, 32'(out), 0);

        // Key 1 for 4 edges, then key 2: pulse on 7th edge of key 2.
        keypad = 10'b0000000010;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("t3a_out", e, 32'(out), 0);
        end
        keypad = 10'b0000000100;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("t3b_out", e, 32'(out), 32'(e == 7));
            chk("t3b_busy", e, 32'(busy), 1);
        end
        chk("t3_code", 7, 32'(key_code), 2);
        keypad = '0;
        tick();

        // Two keys together: rejected and flagged.
        keypad = 10'b0000000011;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("t4_multi", e, 32'(multi), 1);
            chk("t4_out", e, 32'(out), 0);
            chk("t4_busy", e, 32'(busy), 0);
        end
        keypad = '0;
        tick();
        chk("t4_rel_multi", 11, 32'(multi), 0);
        chk("t4_code", 11, 32'(key_code), 2);

        // Key 5 held, clear at edge 5, key still held afterwards.
        keypad = 10'b0000100000;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("t5a_out", e, 32'(out), 0);
        end
        clear = 1'b1;
        tick();
        chk("t5_clr_out", 5, 32'(out), 0);
        chk("t5_clr_code", 5, 32'(key_code), 0);
        chk("t5_clr_multi", 5, 32'(multi), 0);
        chk("t5_clr_busy", 5, 32'(busy), 0);
        clear = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("t5b_out", e, 32'(out), 32'(e == 7));
            chk("t5b_busy", e, 32'(busy), 1);
        end
        chk("t5_code", 7, 32'(key_code), 5);
        keypad = '0;
        tick();
        chk("t5_rel_busy", 8, 32'(busy), 0);

        // Key 3 held 20 edges: repeat pulses only with auto-repeat.
        keypad = 10'b0000001000;
        for (int e = 1; e <= 20; e++) begin
            tick();
`ifdef KEYPAD_AUTOREPEAT_EN
            exp_out = (e == 7) || (e == 11) || (e == 15) || (e == 19);
`else
            exp_out = (e == 7);
`endif
            chk("t6_out", e, 32'(out), 32'(exp_out));
            chk("t6_busy", e, 32'(busy), 1);
            if (e >= 7) chk("t6_code", e, 32'(key_code), 3);
        end

        // Key 9 pressed straight over held key 3: tracked as a new press.
        keypad = 10'b1000000000;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("t7_out", e, 32'(out), 32'(e == 7));
            if (e < 7) chk("t7_code_old", e, 32'(key_code), 3);
        end
        chk("t7_code", 7, 32'(key_code), 9);

        // Extra line while fired: flagged, no pulse, stays busy.
        keypad = 10'b1000000001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("t8_multi", e, 32'(multi), 1);
            chk("t8_out", e, 32'(out), 0);
            chk("t8_busy", e, 32'(busy), 1);
        end
        keypad = 10'b1000000000;
        for (int e = 4; e <= 6; e++) begin
            tick();
            chk("t8b_out", e, 32'(out), 0);
            chk("t8b_multi", e, 32'(multi), 0);
            chk("t8b_busy", e, 32'(busy), 1);
        end
        chk("t8_code", 6, 32'(key_code), 9);
        keypad = '0;
        tick();
        chk("t8_rel_busy", 7, 32'(busy), 0);
        chk("t8_rel_out", 7, 32'(out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
